haraka_perm_core: RTL and testbench



---
 rtl/haraka_pkg.sv | 66 ++++++
 rtl/haraka_perm_core_aes_round.sv | 26 ++
 rtl/haraka_perm_core.sv | 126 ++++++++++++
 tb/tb_haraka_perm_core.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/haraka_pkg.sv
// Shared Haraka v2 definitions: AES byte primitives, 32-bit lane shuffles and the core FSM states.
package haraka_pkg;

   localparam int LANE_W = 128;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Entry 0 sits in the most significant byte so the table reads in FIPS-197 order.
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX_TABLE[8*(255 - int'(x)) +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul3(input logic [7:0] x);
      return xtime(x) ^ x;
   endfunction

   // Word 0 is the least significant 32 bits of a lane.
   function automatic logic [127:0] unpacklo(input logic [127:0] a, input logic [127:0] b);
      return {b[63:32], a[63:32], b[31:0], a[31:0]};
   endfunction

   function automatic logic [127:0] unpackhi(input logic [127:0] a, input logic [127:0] b);
      return {b[127:96], a[127:96], b[95:64], a[95:64]};
   endfunction

   function automatic logic [255:0] mix256(input logic [255:0] s);
      return {unpackhi(s[127:0], s[255:128]), unpacklo(s[127:0], s[255:128])};
   endfunction

   function automatic logic [511:0] mix512(input logic [511:0] s);
      logic [127:0] t, a, b, c;
      t = unpacklo(s[127:0],   s[255:128]);
      a = unpackhi(s[127:0],   s[255:128]);
      b = unpacklo(s[383:256], s[511:384]);
      c = unpackhi(s[383:256], s[511:384]);
      return {unpacklo(a, c), unpackhi(b, t), unpacklo(b, t), unpackhi(a, c)};
   endfunction

endpackage

// File: rtl/haraka_perm_core_aes_round.sv
// One combinational AES encryption round (SubBytes, ShiftRows, MixColumns, AddRoundKey) on one lane.
module aes_round
   import haraka_pkg::*;
(
   input  logic [127:0] i_state,
   input  logic [127:0] i_rc,
   output logic [127:0] o_state
);

   logic [7:0]   w_sr [16];
   logic [127:0] w_mc;

   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         // ShiftRows is wiring: row r of column c is taken from column (c+r) mod 4.
         assign w_sr[4*c+r] = sbox(i_state[8*(4*((c+r)%4)+r) +: 8]);
      end
      assign w_mc[32*c+0  +: 8] = xtime(w_sr[4*c])   ^ gmul3(w_sr[4*c+1]) ^ w_sr[4*c+2]        ^ w_sr[4*c+3];
      assign w_mc[32*c+8  +: 8] = w_sr[4*c]          ^ xtime(w_sr[4*c+1]) ^ gmul3(w_sr[4*c+2]) ^ w_sr[4*c+3];
      assign w_mc[32*c+16 +: 8] = w_sr[4*c]          ^ w_sr[4*c+1]        ^ xtime(w_sr[4*c+2]) ^ gmul3(w_sr[4*c+3]);
      assign w_mc[32*c+24 +: 8] = gmul3(w_sr[4*c])   ^ w_sr[4*c+1]        ^ w_sr[4*c+2]        ^ xtime(w_sr[4*c+3]);
   end

   assign o_state = w_mc ^ i_rc;

endmodule

// File: rtl/haraka_perm_core.sv
// Iterative Haraka v2 permutation (256 or 512 bit): one AES layer per cycle, lane mix after every odd layer,
// optional feed-forward to produce the compression output.
module haraka_perm_core
   import haraka_pkg::*;
#(
   parameter  int LANES  = 4,
   parameter  int ROUNDS = 5,
   localparam int W      = LANES * LANE_W,
   localparam int NRC    = 2 * ROUNDS * LANES
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [W-1:0]          in_data,
   input  logic                  in_ffwd,
   input  logic [NRC*LANE_W-1:0] rc,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [W-1:0]          out_data,
   output logic                  busy
);

   localparam int         NLAYER     = 2 * ROUNDS;
   localparam logic [3:0] LAST_LAYER = 4'(NLAYER - 1);

   if (!(LANES == 2 || LANES == 4) || ROUNDS < 1 || ROUNDS > 8) begin : g_badParam
      $error("haraka_perm_core: LANES must be 2 or 4 and ROUNDS must be 1..8");
   end

   state_t       r_fsm;
   state_t       w_fsmNext;
   logic [W-1:0] r_state;
   logic [W-1:0] r_saved;
   logic [W-1:0] r_outData;
   logic         r_ffwd;
   logic [3:0]   r_layer;
   logic [W-1:0] w_aesOut;
   logic [W-1:0] w_mixed;
   logic [W-1:0] w_layerRes;
   logic         w_accept;
   logic         w_last;

   // Lane i of layer L consumes round constant L*LANES + i.
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [LANE_W-1:0] w_rcSel;
      assign w_rcSel = rc[LANE_W*(int'(r_layer)*LANES + i) +: LANE_W];
      aes_round u_round (
         .i_state (r_state[LANE_W*i +: LANE_W]),
         .i_rc    (w_rcSel),
         .o_state (w_aesOut[LANE_W*i +: LANE_W])
      );
   end

   if (LANES == 4) begin : g_mix512
      assign w_mixed = mix512(w_aesOut);
   end else begin : g_mix256
      assign w_mixed = mix256(w_aesOut);
   end

   assign w_layerRes = r_layer[0] ? w_mixed : w_aesOut;
   assign w_last     = (r_layer == LAST_LAYER);
   assign out_data   = r_outData;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fsm <= IDLE;
      end else begin
         r_fsm <= w_fsmNext;
      end
   end

   always_comb begin
      w_fsmNext = r_fsm;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      w_accept  = 1'b0;
      case (r_fsm)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_accept  = 1'b1;
               w_fsmNext = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (w_last) begin
               w_fsmNext = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) begin
               w_fsmNext = IDLE;
            end
         end
         default: w_fsmNext = IDLE;
      endcase
   end

   // out_data only changes on the final layer, so it holds through DONE and after the handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= '0;
         r_saved   <= '0;
         r_outData <= '0;
         r_ffwd    <= 1'b0;
         r_layer   <= '0;
      end else if (w_accept) begin
         r_state <= in_data;
         r_saved <= in_data;
         r_ffwd  <= in_ffwd;
         r_layer <= '0;
      end else if (r_fsm == RUN) begin
         r_state <= w_layerRes;
         r_layer <= r_layer + 4'd1;
         if (w_last) begin
            r_outData <= r_ffwd ? (w_layerRes ^ r_saved) : w_layerRes;
         end
      end
   end

endmodule

// File: tb/tb_haraka_perm_core.sv
// Directed bench for haraka_perm_core: Haraka-512, Haraka-256 and a single-round instance against an
// independently written reference model plus hand-derived constant results.
module tb_haraka_perm_core;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [5119:0] rcAll;
   logic [1023:0] rcC;

   logic         inValidA, inReadyA, inFfwdA, outValidA, outReadyA, busyA;
   logic [511:0] inDataA, outDataA;
   logic         inValidB, inReadyB, inFfwdB, outValidB, outReadyB, busyB;
   logic [255:0] inDataB, outDataB;
   logic         inValidC, inReadyC, inFfwdC, outValidC, outReadyC, busyC;
   logic [511:0] inDataC, outDataC;

   haraka_perm_core #(.LANES(4), .ROUNDS(5)) dutA (
      .clk(clk), .rst(rst), .in_valid(inValidA), .in_ready(inReadyA), .in_data(inDataA),
      .in_ffwd(inFfwdA), .rc(rcAll), .out_valid(outValidA), .out_ready(outReadyA),
      .out_data(outDataA), .busy(busyA));

   haraka_perm_core #(.LANES(2), .ROUNDS(5)) dutB (
      .clk(clk), .rst(rst), .in_valid(inValidB), .in_ready(inReadyB), .in_data(inDataB),
      .in_ffwd(inFfwdB), .rc(rcAll[2559:0]), .out_valid(outValidB), .out_ready(outReadyB),
      .out_data(outDataB), .busy(busyB));

   haraka_perm_core #(.LANES(4), .ROUNDS(1)) dutC (
      .clk(clk), .rst(rst), .in_valid(inValidC), .in_ready(inReadyC), .in_data(inDataC),
      .in_ffwd(inFfwdC), .rc(rcC), .out_valid(outValidC), .out_ready(outReadyC),
      .out_data(outDataC), .busy(busyC));

   // Reference model: S-box derived from the GF(2^8) inverse and affine map, MixColumns in circulant form,
   // lane mix as a word-index table derived from the unpack definitions.
   logic [7:0] sboxM [256];
   int mix4Tab [16] = '{3, 11, 7, 15, 8, 0, 12, 4, 9, 1, 13, 5, 2, 10, 6, 14};
   int mix2Tab [8]  = '{0, 4, 1, 5, 2, 6, 3, 7};

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00; x = a; y = b;
      for (int n = 0; n < 8; n++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      return 8'((x << n) | (x >> (8 - n)));
   endfunction

   task automatic applyStimulus_buildSbox;
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         if (x != 0) begin
            inv = 8'h01;
            for (int e = 0; e < 254; e++) inv = gm(inv, 8'(x));
         end
         sboxM[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] aesModel(input logic [127:0] x, input logic [127:0] k);
      logic [7:0]   st [4][4];
      logic [7:0]   sr [4][4];
      logic [127:0] y;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) st[r][c] = sboxM[x[8*(4*c+r) +: 8]];
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) sr[r][c] = st[r][(c+r)%4];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            y[8*(4*c+r) +: 8] = gm(8'h02, sr[r][c]) ^ gm(8'h03, sr[(r+1)%4][c]) ^ sr[(r+2)%4][c] ^ sr[(r+3)%4][c];
      return y ^ k;
   endfunction

   function automatic logic [511:0] mixModel(input logic [511:0] s, input int lanes);
      logic [511:0] y;
      y = '0;
      for (int o = 0; o < 4*lanes; o++) begin
         if (lanes == 4) y[32*o +: 32] = s[32*mix4Tab[o] +: 32];
         else            y[32*o +: 32] = s[32*mix2Tab[o] +: 32];
      end
      return y;
   endfunction

   function automatic logic [511:0] model(input logic [511:0] din, input logic [5119:0] rcv,
                                          input int lanes, input int rounds, input logic f);
      logic [511:0] s, t;
      s = din;
      for (int L = 0; L < 2*rounds; L++) begin
         t = '0;
         for (int i = 0; i < lanes; i++)
            t[128*i +: 128] = aesModel(s[128*i +: 128], rcv[128*(L*lanes+i) +: 128]);
         if (L % 2 == 1) t = mixModel(t, lanes);
         s = t;
      end
      if (f) s = s ^ din;
      return s;
   endfunction

   task automatic startA(input logic [511:0] d, input logic f);
      inDataA = d; inFfwdA = f; inValidA = 1'b1;
      @(posedge clk); #1;
      inValidA = 1'b0;
   endtask

   task automatic waitA(output int cyc);
      cyc = 0;
      while (outValidA !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      checks++; if (inReadyA !== 1'b1) begin errors++; $display("[TB] FAIL rst_inReadyA: got %b expected 1", inReadyA); end
      checks++; if (outValidA !== 1'b0) begin errors++; $display("[TB] FAIL rst_outValidA: got %b expected 0", outValidA); end
      checks++; if (busyA !== 1'b0) begin errors++; $display("[TB] FAIL rst_busyA: got %b expected 0", busyA); end
      checks++; if (outDataA !== '0) begin errors++; $display("[TB] FAIL rst_outDataA: got %h expected 0", outDataA); end
      checks++; if (inReadyB !== 1'b1) begin errors++; $display("[TB] FAIL rst_inReadyB: got %b expected 1", inReadyB); end
      checks++; if (outValidB !== 1'b0) begin errors++; $display("[TB] FAIL rst_outValidB: got %b expected 0", outValidB); end
      checks++; if (busyB !== 1'b0) begin errors++; $display("[TB] FAIL rst_busyB: got %b expected 0", busyB); end
      checks++; if (outDataB !== '0) begin errors++; $display("[TB] FAIL rst_outDataB: got %h expected 0", outDataB); end
      checks++; if (inReadyC !== 1'b1) begin errors++; $display("[TB] FAIL rst_inReadyC: got %b expected 1", inReadyC); end
      checks++; if (outValidC !== 1'b0) begin errors++; $display("[TB] FAIL rst_outValidC: got %b expected 0", outValidC); end
      checks++; if (busyC !== 1'b0) begin errors++; $display("[TB] FAIL rst_busyC: got %b expected 0", busyC); end
      checks++; if (outDataC !== '0) begin errors++; $display("[TB] FAIL rst_outDataC: got %h expected 0", outDataC); end
   endtask

   task automatic test_perm512(input logic f);
      logic [511:0] din, expv;
      int cyc;
      for (int j = 0; j < 64; j++) din[8*j +: 8] = 8'(j);
      expv = model(din, rcAll, 4, 5, f);
      outReadyA = 1'b0;
      startA(din, f);
      checks++; if (inReadyA !== 1'b0) begin errors++; $display("[TB] FAIL p512_inReadyFall ffwd=%b: got %b expected 0", f, inReadyA); end
      waitA(cyc);
      checks++; if (cyc != 10) begin errors++; $display("[TB] FAIL p512_latency ffwd=%b: got %0d expected 10", f, cyc); end
      checks++; if (outDataA !== expv) begin errors++; $display("[TB] FAIL p512_data ffwd=%b: got %h expected %h", f, outDataA, expv); end
      outReadyA = 1'b1;
      @(posedge clk); #1;
      outReadyA = 1'b0;
      checks++; if (inReadyA !== 1'b1 || outValidA !== 1'b0) begin errors++; $display("[TB] FAIL p512_handshake: got inReady=%b outValid=%b expected 1 0", inReadyA, outValidA); end
   endtask

   task automatic test_perm256;
      logic [255:0] din, expv;
      logic [511:0] m;
      int cyc;
      for (int j = 0; j < 32; j++) din[8*j +: 8] = 8'(j);
      m = model({256'b0, din}, rcAll, 2, 5, 1'b1);
      expv = m[255:0];
      outReadyB = 1'b0;
      inDataB = din; inFfwdB = 1'b1; inValidB = 1'b1;
      @(posedge clk); #1;
      inValidB = 1'b0;
      checks++; if (inReadyB !== 1'b0) begin errors++; $display("[TB] FAIL p256_inReadyFall: got %b expected 0", inReadyB); end
      cyc = 0;
      while (outValidB !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
      checks++; if (cyc != 10) begin errors++; $display("[TB] FAIL p256_latency: got %0d expected 10", cyc); end
      checks++; if (outDataB !== expv) begin errors++; $display("[TB] FAIL p256_data: got %h expected %h", outDataB, expv); end
      outReadyB = 1'b1;
      @(posedge clk); #1;
      outReadyB = 1'b0;
      checks++; if (inReadyB !== 1'b1 || busyB !== 1'b0) begin errors++; $display("[TB] FAIL p256_handshake: got inReady=%b busy=%b expected 1 0", inReadyB, busyB); end
   endtask

   task automatic test_backpressure;
      logic [511:0] din, expv;
      int cyc;
      for (int j = 0; j < 64; j++) din[8*j +: 8] = 8'(j*7 + 3);
      expv = model(din, rcAll, 4, 5, 1'b0);
      outReadyA = 1'b0;
      startA(din, 1'b0);
      waitA(cyc);
      checks++; if (cyc != 10) begin errors++; $display("[TB] FAIL bp_latency: got %0d expected 10", cyc); end
      for (int k = 0; k < 7; k++) begin
         inDataA = ~din;
         inValidA = (k >= 2 && k <= 4);
         @(posedge clk); #1;
         checks++; if (outValidA !== 1'b1 || outDataA !== expv) begin errors++; $display("[TB] FAIL bp_stall%0d: got valid=%b data=%h expected 1 %h", k, outValidA, outDataA, expv); end
      end
      inValidA = 1'b0;
      outReadyA = 1'b1;
      @(posedge clk); #1;
      outReadyA = 1'b0;
      checks++; if (inReadyA !== 1'b1 || outValidA !== 1'b0) begin errors++; $display("[TB] FAIL bp_release: got inReady=%b outValid=%b expected 1 0", inReadyA, outValidA); end
      checks++; if (outDataA !== expv) begin errors++; $display("[TB] FAIL bp_retain: got %h expected %h", outDataA, expv); end
      repeat (2) @(posedge clk);
      #1;
      checks++; if (busyA !== 1'b0) begin errors++; $display("[TB] FAIL bp_notQueued: got busy=%b expected 0", busyA); end
   endtask

   task automatic test_back_to_back;
      logic [511:0] d1, d2, e1, e2;
      int cyc;
      for (int j = 0; j < 64; j++) begin d1[8*j +: 8] = 8'(255 - j); d2[8*j +: 8] = 8'(j*13 + 1); end
      e1 = model(d1, rcAll, 4, 5, 1'b1);
      e2 = model(d2, rcAll, 4, 5, 1'b0);
      outReadyA = 1'b1;
      inDataA = d1; inFfwdA = 1'b1; inValidA = 1'b1;
      @(posedge clk); #1;
      inDataA = d2; inFfwdA = 1'b0;
      waitA(cyc);
      checks++; if (cyc != 10 || outDataA !== e1) begin errors++; $display("[TB] FAIL b2b_first: got lat=%0d data=%h expected 10 %h", cyc, outDataA, e1); end
      cyc = 0;
      do begin @(posedge clk); #1; cyc++; end while (outValidA !== 1'b1 && cyc < 200);
      checks++; if (cyc != 12) begin errors++; $display("[TB] FAIL b2b_interval: got %0d expected 12", cyc); end
      checks++; if (outDataA !== e2) begin errors++; $display("[TB] FAIL b2b_second: got %h expected %h", outDataA, e2); end
      inValidA = 1'b0;
      @(posedge clk); #1;
      outReadyA = 1'b0;
      checks++; if (inReadyA !== 1'b1) begin errors++; $display("[TB] FAIL b2b_idle: got %b expected 1", inReadyA); end
   endtask

   task automatic test_reset_midrun;
      logic [511:0] din, expv;
      int cyc;
      for (int j = 0; j < 64; j++) din[8*j +: 8] = 8'(j ^ 8'h5a);
      outReadyA = 1'b0;
      startA(din, 1'b0);
      repeat (4) begin @(posedge clk); #1; end
      #3 rst = 1'b1;
      #1;
      checks++; if (outValidA !== 1'b0) begin errors++; $display("[TB] FAIL mrst_outValid: got %b expected 0", outValidA); end
      checks++; if (busyA !== 1'b0) begin errors++; $display("[TB] FAIL mrst_busy: got %b expected 0", busyA); end
      checks++; if (inReadyA !== 1'b1) begin errors++; $display("[TB] FAIL mrst_inReady: got %b expected 1", inReadyA); end
      checks++; if (outDataA !== '0) begin errors++; $display("[TB] FAIL mrst_outData: got %h expected 0", outDataA); end
      #2 rst = 1'b0;
      @(posedge clk); #1;
      expv = model(din, rcAll, 4, 5, 1'b1);
      startA(din, 1'b1);
      waitA(cyc);
      checks++; if (cyc != 10) begin errors++; $display("[TB] FAIL mrst_latency: got %0d expected 10", cyc); end
      checks++; if (outDataA !== expv) begin errors++; $display("[TB] FAIL mrst_data: got %h expected %h", outDataA, expv); end
      outReadyA = 1'b1;
      @(posedge clk); #1;
      outReadyA = 1'b0;
   endtask

   task automatic runC(input logic [511:0] d, input logic f, output int cyc);
      inDataC = d; inFfwdC = f; inValidC = 1'b1;
      @(posedge clk); #1;
      inValidC = 1'b0;
      cyc = 0;
      while (outValidC !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
   endtask

   task automatic test_zero_round;
      logic [511:0] din, expv;
      int cyc;
      outReadyC = 1'b0;
      rcC = '0;
      // Zero lanes: layer 0 gives 0x63 bytes, layer 1 gives S(0x63)=0xfb; uniform columns pass MixColumns unchanged.
      runC('0, 1'b0, cyc);
      checks++; if (cyc != 2) begin errors++; $display("[TB] FAIL zr_latency: got %0d expected 2", cyc); end
      checks++; if (outDataC !== {64{8'hfb}}) begin errors++; $display("[TB] FAIL zr_data: got %h expected all fb", outDataC); end
      outReadyC = 1'b1;
      @(posedge clk); #1;
      outReadyC = 1'b0;
      rcC = rcAll[1023:0];
      for (int j = 0; j < 64; j++) din[8*j +: 8] = 8'(j*29 + 17);
      expv = model(din, {4096'b0, rcC}, 4, 1, 1'b1);
      runC(din, 1'b1, cyc);
      checks++; if (cyc != 2) begin errors++; $display("[TB] FAIL r1_latency: got %0d expected 2", cyc); end
      checks++; if (outDataC !== expv) begin errors++; $display("[TB] FAIL r1_mixData: got %h expected %h", outDataC, expv); end
      outReadyC = 1'b1;
      @(posedge clk); #1;
      outReadyC = 1'b0;
   endtask

   initial begin
      inValidA = 1'b0; inFfwdA = 1'b0; outReadyA = 1'b0; inDataA = '0;
      inValidB = 1'b0; inFfwdB = 1'b0; outReadyB = 1'b0; inDataB = '0;
      inValidC = 1'b0; inFfwdC = 1'b0; outReadyC = 1'b0; inDataC = '0;
      rcC = '0;
      for (int k = 0; k < 160; k++) rcAll[32*k +: 32] = 32'(32'h9e3779b9 * (k + 1)) ^ 32'h0684704c;
      applyStimulus_buildSbox();
      test_reset();
      test_perm512(1'b0);
      test_perm512(1'b1);
      test_perm256();
      test_backpressure();
      test_back_to_back();
      test_reset_midrun();
      test_zero_round();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
